// File: rtl/timer_pkg.sv
// Shared types and constants for the timer_counter block and its prescaler.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Step divider for timer_counter: tick asserts once every prescale+1 run cycles.
// Built only when TIMER_COUNTER_PRESCALE_EN is defined; otherwise tick is constant 1 and no flops exist.
module tick_prescaler #(
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             clr,
    input  logic [PRE_W-1:0] prescale,
    output logic             tick
);

`ifdef TIMER_COUNTER_PRESCALE_EN
    logic [PRE_W-1:0] cnt_q;
    logic [PRE_W-1:0] cnt_d;

    // >= rather than == so a prescale lowered below the current count
    // wraps on the next cycle instead of running all the way round.
    assign tick = (cnt_q >= prescale);

    // NOTE: cnt_d gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + PRE_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, run, clr, prescale};
    assign tick          = 1'b1;
`endif

endmodule

// File: rtl/timer_counter.sv
// Modulo up/down timer with load, one-shot stop and optional step prescaler.
// Optional feature macro: TIMER_COUNTER_PRESCALE_EN (prescaler present when defined).
module timer_counter
    import timer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             dir,
    input  logic             one_shot,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic [1:0]       state
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    function automatic logic [WIDTH-1:0] add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        return a + b;
    endfunction

    function automatic logic [WIDTH-1:0] word_mux(input logic             sel,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        return sel ? b : a;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;

    logic             run;
    logic             tick;
    logic             step;
    logic             terminal;
    logic [WIDTH-1:0] limit_m1;
    logic [WIDTH-1:0] step_val;

    assign run  = (state_q == RUN) && en && !load;
    assign step = run && tick;

    tick_prescaler #(
        .PRE_W(PRE_W)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .clr     (load),
        .prescale(prescale),
        .tick    (tick)
    );

    // limit=0 wraps to all-ones here, which is exactly L-1 for L = 2^WIDTH.
    always_comb begin
        limit_m1 = add(limit, ALL_ONES);
        if (dir == UP) begin
            terminal = (count_q >= limit_m1);
            step_val = word_mux(terminal, add(count_q, ONE), '0);
        end else begin
            terminal = (count_q == '0);
            step_val = word_mux(terminal, add(count_q, ALL_ONES), limit_m1);
        end
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (step) begin
            count_d = step_val;
            tc_d    = terminal;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = en ? RUN : IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = en ? RUN : IDLE;
                RUN: begin
                    if (!en) begin
                        state_d = IDLE;
                    end else if (step && terminal && one_shot) begin
                        state_d = DONE;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    always_comb begin
        count = count_q;
        tc    = tc_q;
        state = state_q;
    end

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter (WIDTH=8), with and without TIMER_COUNTER_PRESCALE_EN.
module tb_timer_counter;

`ifdef TIMER_COUNTER_PRESCALE_EN
    localparam int PDIV = 3;
`else
    localparam int PDIV = 1;
`endif

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_DONE = 2;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] limit;
    logic       dir;
    logic       one_shot;
    logic [7:0] prescale;
    logic [7:0] count;
    logic       tc;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    timer_counter #(
        .WIDTH(8),
        .PRE_W(8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .load    (load),
        .load_val(load_val),
        .limit   (limit),
        .dir     (dir),
        .one_shot(one_shot),
        .prescale(prescale),
        .count   (count),
        .tc      (tc),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input int exp_count, input int exp_tc, input int exp_state);
        check({tag, ".count"}, int'(count), exp_count);
        check({tag, ".tc"},    int'(tc),    exp_tc);
        check({tag, ".state"}, int'(state), exp_state);
    endtask

    task automatic edge_clk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; limit = '0;
        dir = 1'b0; one_shot = 1'b0; prescale = '0;

        #2 reset = 1'b0;
        #1 chk("reset", 0, 0, S_IDLE);
        #9 reset = 1'b1;
        edge_clk();
        chk("idle_hold", 0, 0, S_IDLE);

        // Up count, limit 5
        limit = 8'd5; en = 1'b1;
        edge_clk(); chk("up_start", 0, 0, S_RUN);
        edge_clk(); chk("up_1", 1, 0, S_RUN);
        edge_clk(); chk("up_2", 2, 0, S_RUN);
        edge_clk(); chk("up_3", 3, 0, S_RUN);
        edge_clk(); chk("up_4", 4, 0, S_RUN);
        edge_clk(); chk("up_wrap", 0, 1, S_RUN);
        edge_clk(); chk("up_after", 1, 0, S_RUN);
        en = 1'b0;
        edge_clk(); chk("up_stop", 1, 0, S_IDLE);

        // Down count, limit 4, load 2
        limit = 8'd4; dir = 1'b1; load_val = 8'd2; load = 1'b1;
        edge_clk(); chk("dn_load", 2, 0, S_IDLE);
        load = 1'b0; en = 1'b1;
        edge_clk(); chk("dn_start", 2, 0, S_RUN);
        edge_clk(); chk("dn_1", 1, 0, S_RUN);
        edge_clk(); chk("dn_0", 0, 0, S_RUN);
        edge_clk(); chk("dn_wrap", 3, 1, S_RUN);
        edge_clk(); chk("dn_2", 2, 0, S_RUN);

        // One-shot up, limit 3
        en = 1'b0; load = 1'b1; load_val = 8'd0; dir = 1'b0; limit = 8'd3; one_shot = 1'b1;
        edge_clk(); chk("os_load", 0, 0, S_IDLE);
        load = 1'b0; en = 1'b1;
        edge_clk(); chk("os_start", 0, 0, S_RUN);
        edge_clk(); chk("os_1", 1, 0, S_RUN);
        edge_clk(); chk("os_2", 2, 0, S_RUN);
        edge_clk(); chk("os_term", 0, 1, S_DONE);
        edge_clk(); chk("os_hold", 0, 0, S_DONE);
        en = 1'b0;
        edge_clk(); chk("os_en0", 0, 0, S_DONE);
        en = 1'b1;
        edge_clk(); chk("os_en1", 0, 0, S_DONE);
        load = 1'b1; load_val = 8'd7;
        edge_clk(); chk("os_reload", 7, 0, S_RUN);
        load = 1'b0;
        edge_clk(); chk("os_above_lim", 0, 1, S_DONE);

        // Load colliding with a terminal step, then limit 1
        load = 1'b1; load_val = 8'd2;
        edge_clk(); chk("col_setup", 2, 0, S_RUN);
        load_val = 8'd5;
        edge_clk(); chk("col_load", 5, 0, S_RUN);
        load = 1'b0; limit = 8'd1; one_shot = 1'b0;
        edge_clk(); chk("lim1_a", 0, 1, S_RUN);
        edge_clk(); chk("lim1_b", 0, 1, S_RUN);

        // Down from above the limit, then asynchronous reset mid-count
        dir = 1'b1; limit = 8'd4; load = 1'b1; load_val = 8'd10;
        edge_clk(); chk("dn_big_load", 10, 0, S_RUN);
        load = 1'b0;
        edge_clk(); chk("dn_big_9", 9, 0, S_RUN);
        #2 reset = 1'b0;
        #1 chk("async_rst", 0, 0, S_IDLE);
        #2 reset = 1'b1;
        edge_clk(); chk("rst_resume", 0, 0, S_RUN);
        edge_clk(); chk("rst_wrap", 3, 1, S_RUN);

        // Prescale 2, full range up, 255 -> 0 wrap
        dir = 1'b0; limit = 8'd0; prescale = 8'd2; load = 1'b1; load_val = 8'd253;
        edge_clk(); chk("pre_load", 253, 0, S_RUN);
        load = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            edge_clk();
            chk($sformatf("pre_%0d", i), (253 + i / PDIV) % 256,
                (i == 3 * PDIV) ? 1 : 0, S_RUN);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
